// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR)
// with carry-out and valid/ready handshakes on both sides.
// Optional build macro: SHIFTER_RRX_EN (ROR by zero performs RRX).
module shift_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int AMTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    localparam int LOGW = $clog2(WIDTH);
    localparam int LO_W = (LOGW + 1) / 2;
    localparam int HI_W = LOGW - LO_W;
    localparam logic [AMTW-1:0] W_AMT = AMTW'(WIDTH);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {CLS_ZERO, CLS_LT, CLS_EQ, CLS_GT} cls_t;

    // Left shift; returns {carry, data}, carry is the last bit shifted out.
    function automatic logic [WIDTH:0] f_shl(input logic [WIDTH-1:0] d,
                                             input logic [LOGW-1:0] k,
                                             input logic c);
        logic [WIDTH:0] t;
        t = {1'b0, d} << k;
        return (k == '0) ? {c, d} : t;
    endfunction

    // Right shift (logical or arithmetic); returns {carry, data}.
    function automatic logic [WIDTH:0] f_shr(input logic [WIDTH-1:0] d,
                                             input logic [LOGW-1:0] k,
                                             input logic c,
                                             input logic arith);
        logic        [WIDTH:0] u;
        logic signed [WIDTH:0] s;
        u = {d, 1'b0} >> k;
        s = $signed({d, 1'b0}) >>> k;
        if (arith) u = s;
        return (k == '0) ? {c, d} : {u[0], u[WIDTH:1]};
    endfunction

    // Rotate right by k (k < WIDTH).
    function automatic logic [WIDTH-1:0] f_ror(input logic [WIDTH-1:0] d,
                                               input logic [LOGW-1:0] k);
        logic [2*WIDTH-1:0] t;
        t = {d, d} >> k;
        return t[WIDTH-1:0];
    endfunction

    logic             adv;
    logic             vld_p1, vld_p2;
    logic [WIDTH-1:0] data_p1, data_p2;
    logic             carry_p1, cout_p2;
    logic [HI_W-1:0]  hi_p1;
    logic [1:0]       op_p1;
    cls_t             cls_p1;

    cls_t             cls_in;
    logic [LOGW-1:0]  k1, k2;
    logic [WIDTH:0]   s1_nxt, s2_res;
    logic [WIDTH-1:0] rot2;
    logic             byp2;

    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_cout  = cout_p2;

    // ---- stage 1: classify amount, apply low amount bits, resolve special cases ----
    assign k1 = LOGW'(in_amt[LO_W-1:0]);

    // Classify the shift amount relative to the data width.
    always_comb begin
        if (in_amt == '0)        cls_in = CLS_ZERO;
        else if (in_amt < W_AMT) cls_in = CLS_LT;
        else if (in_amt == W_AMT) cls_in = CLS_EQ;
        else                     cls_in = CLS_GT;
    end

    // Stage-1 result: partial shift for in-range amounts, final value otherwise.
    always_comb begin
        s1_nxt = {in_cin, in_data};
        case (in_op)
            OP_LSL: begin
                case (cls_in)
                    CLS_ZERO: s1_nxt = {in_cin, in_data};
                    CLS_LT:   s1_nxt = f_shl(in_data, k1, in_cin);
                    CLS_EQ:   s1_nxt = {in_data[0], {WIDTH{1'b0}}};
                    default:  s1_nxt = '0;
                endcase
            end
            OP_LSR: begin
                case (cls_in)
                    CLS_ZERO: s1_nxt = {in_cin, in_data};
                    CLS_LT:   s1_nxt = f_shr(in_data, k1, in_cin, 1'b0);
                    CLS_EQ:   s1_nxt = {in_data[WIDTH-1], {WIDTH{1'b0}}};
                    default:  s1_nxt = '0;
                endcase
            end
            OP_ASR: begin
                case (cls_in)
                    CLS_ZERO: s1_nxt = {in_cin, in_data};
                    CLS_LT:   s1_nxt = f_shr(in_data, k1, in_cin, 1'b1);
                    default:  s1_nxt = {(WIDTH+1){in_data[WIDTH-1]}};
                endcase
            end
            default: begin
                // Rotation uses the amount modulo WIDTH; carry is taken from the final result.
                if (cls_in == CLS_ZERO) begin
`ifdef SHIFTER_RRX_EN
                    s1_nxt = {in_data[0], in_cin, in_data[WIDTH-1:1]};
`else
                    s1_nxt = {in_cin, in_data};
`endif
                end else begin
                    s1_nxt = {1'b0, f_ror(in_data, k1)};
                end
            end
        endcase
    end

    // Stage-1 data registers; loaded only with real beats so idle data never goes X.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            data_p1  <= s1_nxt[WIDTH-1:0];
            carry_p1 <= s1_nxt[WIDTH];
            hi_p1    <= in_amt[LOGW-1:LO_W];
            op_p1    <= in_op;
            cls_p1   <= cls_in;
        end
    end

    // ---- stage 2: apply high amount bits or pass resolved special cases ----
    assign k2   = {hi_p1, {LO_W{1'b0}}};
    assign byp2 = (cls_p1 == CLS_ZERO) || ((op_p1 != OP_ROR) && (cls_p1 != CLS_LT));
    assign rot2 = f_ror(data_p1, k2);

    // Stage-2 result selection.
    always_comb begin
        s2_res = {carry_p1, data_p1};
        if (!byp2) begin
            case (op_p1)
                OP_LSL:  s2_res = f_shl(data_p1, k2, carry_p1);
                OP_LSR:  s2_res = f_shr(data_p1, k2, carry_p1, 1'b0);
                OP_ASR:  s2_res = f_shr(data_p1, k2, carry_p1, 1'b1);
                default: s2_res = {rot2[WIDTH-1], rot2};
            endcase
        end
    end

    // Valid pipeline and output register; everything holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            cout_p2 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= s2_res[WIDTH-1:0];
                cout_p2 <= s2_res[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Testbench for shift_unit_pipe (WIDTH=32, AMTW=8): directed cases plus random
// traffic checked against a behavioural shifter model and an in-order scoreboard.
module tb_shift_unit_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_amt;
    logic [1:0]  in_op;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_cout;

    int          nvec = 0;
    int          nerr = 0;
    logic [32:0] expq[$];
    logic        hold = 1'b0;
    logic [31:0] held_d;
    logic        held_c;
    logic        obs_valid, obs_cout, obs_ready;
    logic [31:0] obs_data;
    logic        saw_stall;

    shift_unit_pipe #(.WIDTH(32), .AMTW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shifter: returns {carry, result}.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input int n, input logic cin);
        logic [31:0]        r;
        logic               c;
        logic signed [31:0] sd;
        int                 m;
        r = d; c = cin; sd = d;
        case (op)
            2'd0: begin
                if (n == 0) begin r = d; c = cin; end
                else if (n < 32) begin r = d << n; c = d[32-n]; end
                else if (n == 32) begin r = 0; c = d[0]; end
                else begin r = 0; c = 1'b0; end
            end
            2'd1: begin
                if (n == 0) begin r = d; c = cin; end
                else if (n < 32) begin r = d >> n; c = d[n-1]; end
                else if (n == 32) begin r = 0; c = d[31]; end
                else begin r = 0; c = 1'b0; end
            end
            2'd2: begin
                if (n == 0) begin r = d; c = cin; end
                else if (n < 32) begin r = sd >>> n; c = d[n-1]; end
                else begin r = {32{d[31]}}; c = d[31]; end
            end
            default: begin
                m = n % 32;
                if (n == 0) begin
`ifdef SHIFTER_RRX_EN
                    r = {cin, d[31:1]}; c = d[0];
`else
                    r = d; c = cin;
`endif
                end else if (m == 0) begin
                    r = d; c = d[31];
                end else begin
                    r = (d >> m) | (d << (32 - m)); c = r[31];
                end
            end
        endcase
        return {c, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score outputs, record accepted beats.
    task automatic cyc(output bit acc);
        logic [32:0] e;
        @(negedge clk);
        obs_valid = out_valid; obs_data = out_data; obs_cout = out_cout; obs_ready = in_ready;
        acc = 1'b0;
        if (!reset) begin
            if (hold)
                chk("stall_hold", 64'({out_valid, out_cout, out_data}), 64'({1'b1, held_c, held_d}));
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                chk("stall_in_ready", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", 64'(expq.size() > 0), 64'(1));
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("beat_data", 64'({out_cout, out_data}), 64'(e));
                end
            end
            chk("no_x", 64'($isunknown({out_data, out_cout})), 64'(0));
            if (in_valid && in_ready) begin
                acc = 1'b1;
                expq.push_back(model(in_op, in_data, int'(in_amt), in_cin));
            end
            hold = out_valid && !out_ready; held_d = out_data; held_c = out_cout;
        end else begin
            hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Present a beat and wait (bounded) for it to be accepted.
    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [7:0] n, input logic c);
        bit acc;
        in_valid = 1'b1; in_op = op; in_data = d; in_amt = n; in_cin = c;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cyc(acc);
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    // Send one beat and compare the first output beat to constants.
    task automatic beat(input string tag, input logic [1:0] op, input logic [31:0] d,
                        input logic [7:0] n, input logic c,
                        input logic [31:0] exp_d, input logic exp_c);
        bit acc;
        send(op, d, n, c);
        obs_valid = 1'b0;
        for (int i = 0; i < 10 && !obs_valid; i++) cyc(acc);
        chk(tag, 64'({obs_valid, obs_cout, obs_data}), 64'({1'b1, exp_c, exp_d}));
    endtask

    initial begin
        bit acc;
        int nb;
        logic [1:0] ops[4];
        logic [31:0] dats[4];
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_cin = 1'b0;
        out_ready = 1'b1; saw_stall = 1'b0;
        repeat (3) cyc(acc);
        reset = 1'b0;
        cyc(acc);
        chk("reset_state", 64'({obs_valid, obs_cout, obs_data}), 64'(0));
        chk("reset_in_ready", 64'(obs_ready), 64'(1));

        // Test 1: LSL with latency check
        send(2'b00, 32'h8000_0001, 8'd1, 1'b0);
        cyc(acc);
        chk("lat_cycle1", 64'(obs_valid), 64'(0));
        cyc(acc);
        chk("lsl1", 64'({obs_valid, obs_cout, obs_data}), 64'({1'b1, 1'b1, 32'h0000_0002}));
        repeat (2) cyc(acc);

        // Tests 2-4: boundary amounts
        beat("lsr32", 2'b01, 32'h8000_0000, 8'd32, 1'b0, 32'h0, 1'b1);
        beat("asr40", 2'b10, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1);
        beat("ror36", 2'b11, 32'h0000_00F1, 8'd36, 1'b1, 32'h1000_000F, 1'b0);
        beat("ror32", 2'b11, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b1);
`ifdef SHIFTER_RRX_EN
        beat("ror0_rrx", 2'b11, 32'h0000_0003, 8'd0, 1'b1, 32'h8000_0001, 1'b1);
`else
        beat("ror0_plain", 2'b11, 32'h0000_0003, 8'd0, 1'b1, 32'h0000_0003, 1'b1);
`endif
        beat("lsl32", 2'b00, 32'h0000_0001, 8'd32, 1'b0, 32'h0, 1'b1);
        beat("lsl33", 2'b00, 32'hFFFF_FFFF, 8'd33, 1'b1, 32'h0, 1'b0);
        beat("lsr31", 2'b01, 32'h8000_0000, 8'd31, 1'b0, 32'h1, 1'b0);
        repeat (3) cyc(acc);

        // Test 5: four back-to-back beats with a three-cycle output stall
        ops  = '{2'b00, 2'b01, 2'b10, 2'b11};
        dats = '{32'h1234_5678, 32'h8765_4321, 32'hF000_000F, 32'hA5A5_5A5A};
        nb = 0;
        for (int t = 0; t < 14; t++) begin
            out_ready = !(t >= 2 && t < 5);
            if (nb < 4) begin
                in_valid = 1'b1; in_op = ops[nb]; in_data = dats[nb];
                in_amt = 8'(nb * 5 + 3); in_cin = nb[0];
            end else begin
                in_valid = 1'b0;
            end
            cyc(acc);
            if (acc) nb++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_seen", 64'(saw_stall), 64'(1));
        chk("b2b_all_sent", 64'(nb), 64'(4));
        chk("b2b_drained", 64'(expq.size()), 64'(0));

        // Test 6: reset with two beats in flight
        send(2'b00, 32'h0000_00FF, 8'd4, 1'b0);
        send(2'b01, 32'hFF00_0000, 8'd4, 1'b0);
        reset = 1'b1;
        cyc(acc);
        expq.delete();
        cyc(acc);
        chk("reset_flush", 64'({obs_valid, obs_cout, obs_data}), 64'(0));
        reset = 1'b0;
        cyc(acc);
        chk("reset_in_ready2", 64'(obs_ready), 64'(1));
        chk("reset_no_stale", 64'(obs_valid), 64'(0));
        repeat (6) cyc(acc);

        // Random traffic with random bubbles and backpressure
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            in_cin    = 1'($urandom_range(0, 1));
            in_amt    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
            cyc(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) cyc(acc);
        chk("final_drained", 64'(expq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
